gpio_apb_bank_ctrl: RTL and testbench

- Next-generation GPIO peripheral with a native APB slave and no external bus converter.
- Pin count is parametrised and grouped into 32-pin banks.
- Adds a per-pin synchroniser and programmable debounce filter, atomic set/clear of outputs, and per-pin rising/falling edge interrupts with write-1-to-clear status.
- Sits on the peripheral APB segment; drives pads and the interrupt controller.

---
 rtl/gpio_apb_bank_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_gpio_apb_bank_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_bank_ctrl.sv
// GPIO controller with a native APB slave, 32-pin banks, per-pin input
// synchroniser and debounce filter, atomic output set/clear and W1C edge interrupts.
module gpio_apb_bank_ctrl #(
    parameter int unsigned NrGPIOs       = 64,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned DebounceWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [NrGPIOs-1:0]    gpio_in,
    output logic [NrGPIOs-1:0]    gpio_out,
    output logic [NrGPIOs-1:0]    gpio_tx_en_o,
    output logic [NrGPIOs-1:0]    gpio_in_sync_o,
    output logic                  interrupt_o
);
    localparam int unsigned NrBanks = (NrGPIOs + 31) / 32;
    localparam int unsigned PadW    = NrBanks * 32;
    localparam logic [NrBanks-1:0][31:0] ValidMask = {PadW{1'b1}} >> (PadW - NrGPIOs);
    localparam logic [ADDR_WIDTH-1:0]   DebAddr   = ADDR_WIDTH'(32'h400);

    // Elaboration-time parameter sanity
    if (DATA_WIDTH != 32) begin : g_bad_dw
        $error("gpio_apb_bank_ctrl: DATA_WIDTH must be 32");
    end
    if (SyncStages < 2) begin : g_bad_sync
        $error("gpio_apb_bank_ctrl: SyncStages must be >= 2");
    end
    if (NrGPIOs < 1 || NrGPIOs > 1024) begin : g_bad_n
        $error("gpio_apb_bank_ctrl: NrGPIOs must be 1..1024");
    end
    if (ADDR_WIDTH < 11 || DebounceWidth < 1 || DebounceWidth > 32) begin : g_bad_aw
        $error("gpio_apb_bank_ctrl: ADDR_WIDTH >= 11 and DebounceWidth 1..32 required");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic                            wr_q;
    logic [31:0]                     wdata_q;
    logic [NrBanks-1:0][31:0]        dir_q, out_q, rise_q, fall_q, status_q, status_d, set_c;
    logic [DebounceWidth-1:0]        deb_q, deb_m1;
    logic [SyncStages-1:0][NrGPIOs-1:0] sync_q;
    logic [NrGPIOs-1:0]              s_c, d_q, d_prev_q;
    logic [DebounceWidth-1:0]        cnt_q [NrGPIOs];

    logic [4:0]  bank_sel;
    logic [2:0]  reg_sel;
    logic        is_bank, is_deb, err_c, wr_commit;
    logic [31:0] rd_word;

    assign s_c            = sync_q[SyncStages-1];
    assign bank_sel       = addr_q[9:5];
    assign reg_sel        = addr_q[4:2];
    assign is_bank        = addr_q < DebAddr;
    assign is_deb         = addr_q == DebAddr;
    assign deb_m1         = deb_q - DebounceWidth'(1);
    assign gpio_out       = NrGPIOs'(out_q);
    assign gpio_tx_en_o   = NrGPIOs'(dir_q);
    assign gpio_in_sync_o = d_q;

    // Address decode and error classification of the captured transfer
    always_comb begin
        err_c = 1'b0;
        if (addr_q[1:0] != 2'b00)                                err_c = 1'b1;
        if (is_bank && ({1'b0, bank_sel} >= 6'(NrBanks)))         err_c = 1'b1;
        if (!is_bank && !is_deb)                                  err_c = 1'b1;
        if (is_bank && wr_q && (reg_sel == 3'd4))                 err_c = 1'b1;
        wr_commit = (state_q == ACCESS) && wr_q && !err_c;
    end

    // Read data mux; write-only registers read as zero
    always_comb begin
        rd_word = '0;
        if (is_deb) rd_word = 32'(deb_q);
        for (int b = 0; b < int'(NrBanks); b++) begin
            if (is_bank && (bank_sel == 5'(b))) begin
                case (reg_sel)
                    3'd0:    rd_word = dir_q[b];
                    3'd1:    rd_word = out_q[b];
                    3'd4:    rd_word = ValidMask[b] & 32'(PadW'(d_q) >> (32 * b));
                    3'd5:    rd_word = rise_q[b];
                    3'd6:    rd_word = fall_q[b];
                    3'd7:    rd_word = status_q[b];
                    default: rd_word = '0;
                endcase
            end
        end
    end

    // Status update: W1C first, then edge events so that a set wins
    always_comb begin
        set_c    = PadW'(( d_q & ~d_prev_q & NrGPIOs'(rise_q)) |
                         (~d_q &  d_prev_q & NrGPIOs'(fall_q)));
        status_d = status_q;
        for (int b = 0; b < int'(NrBanks); b++) begin
            if (wr_commit && is_bank && (bank_sel == 5'(b)) && (reg_sel == 3'd7)) begin
                status_d[b] = status_q[b] & ~wdata_q;
            end
        end
        status_d = status_d | set_c;
    end

    // APB FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (psel_i && !penable_i) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // APB state, transfer capture and registered response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            pready_o  <= 1'b0;
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && psel_i && !penable_i) begin
                addr_q  <= paddr_i;
                wr_q    <= pwrite_i;
                wdata_q <= pwdata_i;
            end
            pready_o  <= (state_q == ACCESS);
            pslverr_o <= (state_q == ACCESS) && err_c;
            prdata_o  <= ((state_q == ACCESS) && !wr_q && !err_c) ? rd_word : '0;
        end
    end

    // Register file writes, status and interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q       <= '0;
            out_q       <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            status_q    <= '0;
            deb_q       <= '0;
            interrupt_o <= 1'b0;
        end else begin
            status_q    <= status_d;
            interrupt_o <= |status_q;
            if (wr_commit && is_deb) deb_q <= wdata_q[DebounceWidth-1:0];
            for (int b = 0; b < int'(NrBanks); b++) begin
                if (wr_commit && is_bank && (bank_sel == 5'(b))) begin
                    case (reg_sel)
                        3'd0:    dir_q[b]  <= wdata_q & ValidMask[b];
                        3'd1:    out_q[b]  <= wdata_q & ValidMask[b];
                        3'd2:    out_q[b]  <= out_q[b] | (wdata_q & ValidMask[b]);
                        3'd3:    out_q[b]  <= out_q[b] & ~wdata_q;
                        3'd5:    rise_q[b] <= wdata_q & ValidMask[b];
                        3'd6:    fall_q[b] <= wdata_q & ValidMask[b];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Input synchroniser, per-pin debounce filter and edge history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            d_q      <= '0;
            d_prev_q <= '0;
            for (int i = 0; i < int'(NrGPIOs); i++) cnt_q[i] <= '0;
        end else begin
            sync_q   <= {sync_q[SyncStages-2:0], gpio_in};
            d_prev_q <= d_q;
            for (int i = 0; i < int'(NrGPIOs); i++) begin
                if (deb_q == '0) begin
                    d_q[i]   <= s_c[i];
                    cnt_q[i] <= '0;
                end else if (s_c[i] == d_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= deb_m1) begin
                    // >= so a threshold lowered mid-count accepts on the next differing cycle
                    d_q[i]   <= s_c[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DebounceWidth'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gpio_apb_bank_ctrl.sv
// Directed bench for gpio_apb_bank_ctrl with 40 pins (two banks, second partial).
module tb_gpio_apb_bank_ctrl;
    localparam int unsigned N = 40;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          psel_i, penable_i, pwrite_i;
    logic [31:0]   paddr_i, pwdata_i, prdata_o;
    logic          pready_o, pslverr_o, interrupt_o;
    logic [N-1:0]  gpio_in, gpio_out, gpio_tx_en_o, gpio_in_sync_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;

    always #5 clk_i = ~clk_i;

    gpio_apb_bank_ctrl #(
        .NrGPIOs(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SyncStages(2), .DebounceWidth(16)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_tx_en_o(gpio_tx_en_o),
        .gpio_in_sync_o(gpio_in_sync_o), .interrupt_o(interrupt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One APB transfer: setup, access (wait state), response; checks pready timing
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
        chk("pready_setup", 64'(pready_o), 64'd0);
        cyc(1);
        penable_i = 1'b1;
        chk("pready_access", 64'(pready_o), 64'd0);
        cyc(1);
        chk("pready_resp", 64'(pready_o), 64'd1);
        rdata = prdata_o;
        err   = pslverr_o;
        cyc(1);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        chk("idle_pready", 64'(pready_o), 64'd0);
        chk("idle_prdata", 64'(prdata_o), 64'd0);
    endtask

    initial begin
        rst_ni = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = '0; pwdata_i = '0; gpio_in = '0;
        cyc(2);
        chk("rst_gpio_out", 64'(gpio_out), 64'd0);
        chk("rst_tx_en", 64'(gpio_tx_en_o), 64'd0);
        chk("rst_irq", 64'(interrupt_o), 64'd0);
        chk("rst_pready", 64'(pready_o), 64'd0);
        rst_ni = 1'b1;
        cyc(1);

        // Reset values of registers
        apb(1'b0, 32'h00, 32'h0, rd, er); chk("rd_dir0", 64'(rd), 64'h0); chk("rd_dir0_err", 64'(er), 64'd0);
        apb(1'b0, 32'h04, 32'h0, rd, er); chk("rd_out0", 64'(rd), 64'h0); chk("rd_out0_err", 64'(er), 64'd0);
        apb(1'b0, 32'h1C, 32'h0, rd, er); chk("rd_stat0", 64'(rd), 64'h0); chk("rd_stat0_err", 64'(er), 64'd0);
        apb(1'b0, 32'h400, 32'h0, rd, er); chk("rd_deb", 64'(rd), 64'h0); chk("rd_deb_err", 64'(er), 64'd0);

        // Output writes with atomic set/clear
        apb(1'b1, 32'h04, 32'h0000_00F0, rd, er); chk("wr_out_err", 64'(er), 64'd0);
        apb(1'b1, 32'h08, 32'h0000_0003, rd, er);
        apb(1'b1, 32'h0C, 32'h0000_0010, rd, er);
        apb(1'b1, 32'h00, 32'hFFFF_FFFF, rd, er);
        chk("gpio_out_e3", 64'(gpio_out), 64'h00_0000_00E3);
        chk("tx_en_bank0", 64'(gpio_tx_en_o), 64'h00_FFFF_FFFF);
        apb(1'b0, 32'h04, 32'h0, rd, er); chk("rd_out_e3", 64'(rd), 64'hE3);
        apb(1'b0, 32'h08, 32'h0, rd, er); chk("rd_outset", 64'(rd), 64'h0); chk("rd_outset_err", 64'(er), 64'd0);

        // Debounce threshold 4, rising-edge interrupt on pin 5
        apb(1'b1, 32'h400, 32'h4, rd, er);
        apb(1'b0, 32'h400, 32'h0, rd, er); chk("rd_deb4", 64'(rd), 64'h4);
        apb(1'b1, 32'h14, 32'h20, rd, er);
        apb(1'b1, 32'h18, 32'h00, rd, er);

        gpio_in[5] = 1'b1;
        cyc(3);
        gpio_in[5] = 1'b0;
        cyc(10);
        chk("glitch_sync5", 64'(gpio_in_sync_o[5]), 64'd0);
        apb(1'b0, 32'h10, 32'h0, rd, er); chk("glitch_in", 64'(rd), 64'h0);
        chk("glitch_irq", 64'(interrupt_o), 64'd0);

        gpio_in[5] = 1'b1;
        cyc(5);
        chk("hold_sync5_early", 64'(gpio_in_sync_o[5]), 64'd0);
        cyc(1);
        chk("hold_sync5_edge", 64'(gpio_in_sync_o[5]), 64'd1);
        chk("irq_not_yet0", 64'(interrupt_o), 64'd0);
        cyc(1);
        chk("irq_not_yet1", 64'(interrupt_o), 64'd0);
        cyc(1);
        chk("irq_set", 64'(interrupt_o), 64'd1);
        apb(1'b0, 32'h1C, 32'h0, rd, er); chk("stat_rise", 64'(rd), 64'h20);
        apb(1'b0, 32'h10, 32'h0, rd, er); chk("in_bit5", 64'(rd), 64'h20);

        gpio_in[5] = 1'b0;
        cyc(12);
        chk("fall_sync5", 64'(gpio_in_sync_o[5]), 64'd0);
        apb(1'b0, 32'h1C, 32'h0, rd, er); chk("stat_after_fall", 64'(rd), 64'h20);
        chk("irq_held", 64'(interrupt_o), 64'd1);
        apb(1'b1, 32'h1C, 32'h20, rd, er);
        chk("irq_cleared", 64'(interrupt_o), 64'd0);
        apb(1'b0, 32'h1C, 32'h0, rd, er); chk("stat_cleared", 64'(rd), 64'h0);

        // Error responses leave state untouched
        apb(1'b1, 32'h06, 32'h0, rd, er); chk("err_unaligned_wr", 64'(er), 64'd1);
        apb(1'b0, 32'h04, 32'h0, rd, er); chk("out_kept", 64'(rd), 64'hE3);
        apb(1'b0, 32'h1002, 32'h0, rd, er); chk("err_1002", 64'(er), 64'd1); chk("err_1002_rd", 64'(rd), 64'h0);
        apb(1'b1, 32'h40, 32'h0, rd, er); chk("err_bank_wr", 64'(er), 64'd1);
        apb(1'b0, 32'h44, 32'h0, rd, er); chk("err_bank_rd", 64'(er), 64'd1);
        apb(1'b1, 32'h10, 32'hFFFF_FFFF, rd, er); chk("err_wr_in", 64'(er), 64'd1);
        apb(1'b0, 32'h10, 32'h0, rd, er); chk("in_after_err", 64'(rd), 64'h0); chk("in_rd_err", 64'(er), 64'd0);
        apb(1'b1, 32'h404, 32'h0, rd, er); chk("err_404", 64'(er), 64'd1);
        apb(1'b0, 32'h00, 32'h0, rd, er); chk("dir_kept", 64'(rd), 64'hFFFF_FFFF);
        chk("gpio_out_kept", 64'(gpio_out), 64'h00_0000_00E3);

        // Partial bank 1: only 8 pins exist
        apb(1'b1, 32'h24, 32'hFFFF_FFFF, rd, er); chk("b1_wr_err", 64'(er), 64'd0);
        apb(1'b0, 32'h24, 32'h0, rd, er); chk("b1_out_rd", 64'(rd), 64'hFF);
        chk("b1_gpio_out", 64'(gpio_out), 64'hFF_0000_00E3);

        // Reset in the middle of a write: dropped, FSM idle afterwards
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h04; pwdata_i = 32'h55;
        cyc(1);
        penable_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_pready", 64'(pready_o), 64'd0);
        chk("midrst_out", 64'(gpio_out), 64'd0);
        cyc(1);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        rst_ni = 1'b1;
        cyc(1);
        apb(1'b0, 32'h04, 32'h0, rd, er); chk("midrst_rd_out", 64'(rd), 64'h0);

        // DEBOUNCE == 0: debounced value follows synchroniser output
        gpio_in[3] = 1'b1;
        cyc(2);
        chk("deb0_early", 64'(gpio_in_sync_o[3]), 64'd0);
        cyc(1);
        chk("deb0_follow", 64'(gpio_in_sync_o[3]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
